// File: rtl/processor_pkg.sv
// Shared definitions for the 20-bit pipelined processor: ISA fields, fixed opcodes
// and the fetch-stage state encoding. The decode stage imports the same package.
package processor_pkg;

  localparam int INSTR_WIDTH = 20;
  localparam int OPCODE_MSB  = 19;
  localparam int OPCODE_LSB  = 16;

  localparam logic [3:0] HALT_OPCODE  = 4'b1111;
  localparam logic [3:0] STORE_OPCODE = 4'b1100;

  localparam logic [INSTR_WIDTH-1:0] NOP_INSTRUCTION = 20'h00000;

  typedef enum logic {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  function automatic logic is_halt(input logic [INSTR_WIDTH-1:0] word);
    return word[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/instruction_memory.sv
// Instruction store: combinational read port for fetch, synchronous write port
// used to load the program.
module instruction_memory #(
  parameter int ADDR_WIDTH  = 8,
  parameter int INSTR_WIDTH = 20
) (
  input  logic                   clock,
  input  logic                   write_enable,
  input  logic [ADDR_WIDTH-1:0]  write_address,
  input  logic [INSTR_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0]  read_address,
  output logic [INSTR_WIDTH-1:0] read_data
);

  logic [INSTR_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // NOTE: the array deliberately has no reset; a loaded program survives a reset pulse.
  always_ff @(posedge clock) begin
    if (write_enable) mem[write_address] <= write_data;
  end

  // Read is asynchronous, so a same-edge write is seen only by the following fetch.
  assign read_data = mem[read_address];

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: program counter, HALT/FETCH control and the IF/ID register that
// decode reads. Redirect beats stall, stall beats normal fetch.
module instruction_fetch
  import processor_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int INSTR_WIDTH = processor_pkg::INSTR_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   branchTaken,
  input  logic [ADDR_WIDTH-1:0]  branchTarget,
  input  logic                   imemWriteEnable,
  input  logic [ADDR_WIDTH-1:0]  imemWriteAddress,
  input  logic [INSTR_WIDTH-1:0] imemWriteData,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic [ADDR_WIDTH-1:0]  pcOut,
  output logic                   valid,
  output logic                   halted
);

  logic [ADDR_WIDTH-1:0]  pc;
  logic [INSTR_WIDTH-1:0] fetched;
  fetch_state_t           state;

  instruction_memory #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INSTR_WIDTH(INSTR_WIDTH)
  ) u_imem (
    .clock        (clock),
    .write_enable (imemWriteEnable),
    .write_address(imemWriteAddress),
    .write_data   (imemWriteData),
    .read_address (pc),
    .read_data    (fetched)
  );

  // NOTE: every register here is sequential state, so only non-blocking assignments are used.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc          <= '0;
      instruction <= NOP_INSTRUCTION;
      pcOut       <= '0;
      valid       <= 1'b0;
      state       <= FETCH;
      halted      <= 1'b0;
    end else if (branchTaken) begin
      pc          <= branchTarget;
      instruction <= NOP_INSTRUCTION;
      pcOut       <= '0;
      valid       <= 1'b0;
      state       <= FETCH;
      halted      <= 1'b0;
    end else if (!stall) begin
      unique case (state)
        FETCH: begin
          instruction <= fetched;
          pcOut       <= pc;
          valid       <= 1'b1;
          if (is_halt(fetched)) begin
            // The HALT word itself is delivered; the PC stays parked on it.
            state <= HALTED;
          end else begin
            pc <= pc + ADDR_WIDTH'(1);
          end
        end
        HALTED: begin
          instruction <= NOP_INSTRUCTION;
          pcOut       <= '0;
          valid       <= 1'b0;
          halted      <= 1'b1;
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: expected IF/ID contents are queued as
// each edge is driven and compared one cycle later against the DUT outputs.
module tb_instruction_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        branchTaken;
  logic [7:0]  branchTarget;
  logic        imemWriteEnable;
  logic [7:0]  imemWriteAddress;
  logic [19:0] imemWriteData;
  logic [19:0] instruction;
  logic [7:0]  pcOut;
  logic        valid;
  logic        halted;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic [19:0] instr;
    logic [7:0]  pc;
    logic        v;
  } exp_t;

  exp_t sb[$];

  instruction_fetch #(.ADDR_WIDTH(8)) dut (
    .clock           (clock),
    .reset           (reset),
    .stall           (stall),
    .branchTaken     (branchTaken),
    .branchTarget    (branchTarget),
    .imemWriteEnable (imemWriteEnable),
    .imemWriteAddress(imemWriteAddress),
    .imemWriteData   (imemWriteData),
    .instruction     (instruction),
    .pcOut           (pcOut),
    .valid           (valid),
    .halted          (halted)
  );

  always #5 clock = ~clock;

  task automatic expect_edge(input string name, input logic [19:0] instr,
                             input logic [7:0] pc, input logic v);
    exp_t e;
    e.name = name; e.instr = instr; e.pc = pc; e.v = v;
    sb.push_back(e);
  endtask

  // Advance one rising edge, then retire the oldest scoreboard entry.
  task automatic step();
    exp_t e;
    @(posedge clock);
    #1;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty at time %0t", $time);
    end else begin
      e = sb.pop_front();
      if (instruction !== e.instr || pcOut !== e.pc || valid !== e.v) begin
        errors++;
        $display("FAIL %s: got instr=%h pc=%h valid=%b, required instr=%h pc=%h valid=%b",
                 e.name, instruction, pcOut, valid, e.instr, e.pc, e.v);
      end
    end
  endtask

  task automatic load(input logic [7:0] addr, input logic [19:0] data);
    imemWriteEnable = 1'b1; imemWriteAddress = addr; imemWriteData = data;
    @(posedge clock);
    #1;
    imemWriteEnable = 1'b0;
  endtask

  task automatic check_halted(input string name, input logic req);
    checks++;
    if (halted !== req) begin
      errors++;
      $display("FAIL %s: halted=%b required %b", name, halted, req);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; stall = 1'b0; branchTaken = 1'b0; branchTarget = '0;
    imemWriteEnable = 1'b0; imemWriteAddress = '0; imemWriteData = '0;
    #2;
    load(8'h00, 20'hC0F00);
    load(8'h01, 20'hE0F00);
    load(8'h02, 20'h12340);
    load(8'h03, 20'hF0000);
    load(8'h40, 20'hC1200);
    load(8'h41, 20'h00001);
    load(8'hFF, 20'h00077);
    checks++;
    if (instruction !== 20'h0 || pcOut !== 8'h0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: instr=%h pc=%h valid=%b, required 00000/00/0",
               instruction, pcOut, valid);
    end
    check_halted("reset_halted", 1'b0);
    reset = 1'b1;
    expect_edge("fetch0", 20'hC0F00, 8'h00, 1'b1); step();
    expect_edge("fetch1", 20'hE0F00, 8'h01, 1'b1); step();
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expect_edge($sformatf("stall_hold%0d", i), 20'hE0F00, 8'h01, 1'b1);
      step();
    end
    stall = 1'b0;
    expect_edge("stall_resume", 20'h12340, 8'h02, 1'b1); step();
  endtask

  task automatic test_halt();
    expect_edge("halt_word", 20'hF0000, 8'h03, 1'b1); step();
    for (int i = 0; i < 3; i++) begin
      expect_edge($sformatf("halt_bubble%0d", i), 20'h00000, 8'h00, 1'b0);
      step();
      check_halted($sformatf("halted%0d", i), 1'b1);
    end
  endtask

  task automatic test_redirect();
    // Redirect out of HALTED with stall asserted: branch must win.
    branchTaken = 1'b1; branchTarget = 8'h40; stall = 1'b1;
    expect_edge("redirect_bubble", 20'h00000, 8'h00, 1'b0); step();
    check_halted("redirect_clears_halt", 1'b0);
    branchTaken = 1'b0; stall = 1'b0;
    expect_edge("redirect_target", 20'hC1200, 8'h40, 1'b1); step();
    branchTaken = 1'b1; branchTarget = 8'h00;
    expect_edge("redirect0_bubble", 20'h00000, 8'h00, 1'b0); step();
    branchTaken = 1'b0;
    expect_edge("redirect0_target", 20'hC0F00, 8'h00, 1'b1); step();
  endtask

  task automatic test_wrap();
    branchTaken = 1'b1; branchTarget = 8'hFF;
    expect_edge("wrap_bubble", 20'h00000, 8'h00, 1'b0); step();
    branchTaken = 1'b0;
    expect_edge("wrap_ff", 20'h00077, 8'hFF, 1'b1); step();
    expect_edge("wrap_00", 20'hC0F00, 8'h00, 1'b1); step();
  endtask

  task automatic test_collision();
    // pc now points at 1; overwrite it on the same edge it is fetched.
    imemWriteEnable = 1'b1; imemWriteAddress = 8'h01; imemWriteData = 20'hABCDE;
    expect_edge("collision_old", 20'hE0F00, 8'h01, 1'b1); step();
    imemWriteEnable = 1'b0;
    expect_edge("collision_next", 20'h12340, 8'h02, 1'b1); step();
    branchTaken = 1'b1; branchTarget = 8'h01;
    expect_edge("collision_bubble", 20'h00000, 8'h00, 1'b0); step();
    branchTaken = 1'b0;
    expect_edge("collision_new", 20'hABCDE, 8'h01, 1'b1); step();
  endtask

  task automatic test_async_reset();
    expect_edge("pre_reset", 20'h12340, 8'h02, 1'b1); step();
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (instruction !== 20'h0 || pcOut !== 8'h0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: instr=%h pc=%h valid=%b, required 00000/00/0",
               instruction, pcOut, valid);
    end
    check_halted("async_reset_halted", 1'b0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    expect_edge("post_reset_fetch0", 20'hC0F00, 8'h00, 1'b1); step();
    expect_edge("post_reset_fetch1", 20'hABCDE, 8'h01, 1'b1); step();
  endtask

  initial begin
    test_reset();
    test_stall();
    test_halt();
    test_redirect();
    test_wrap();
    test_collision();
    test_async_reset();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
